// File: rtl/acsi_pkg.sv
// Shared definitions for the ACSI initiator: state encodings, bus idle levels
// and timing helpers.
package acsi_pkg;

  typedef logic [3:0] acsi_state_t;

  localparam logic [3:0] ST_IDLE         = 4'd0;
  localparam logic [3:0] ST_CMD_FETCH    = 4'd1;
  localparam logic [3:0] ST_CMD_SETUP    = 4'd2;
  localparam logic [3:0] ST_CMD_STROBE   = 4'd3;
  localparam logic [3:0] ST_CMD_RECOVER  = 4'd4;
  localparam logic [3:0] ST_WAIT_IRQ     = 4'd5;
  localparam logic [3:0] ST_DATA_WAIT    = 4'd6;
  localparam logic [3:0] ST_DATA_FETCH   = 4'd7;
  localparam logic [3:0] ST_DATA_SETUP   = 4'd8;
  localparam logic [3:0] ST_DATA_STROBE  = 4'd9;
  localparam logic [3:0] ST_DATA_RECOVER = 4'd10;
  localparam logic [3:0] ST_RD_HOLD      = 4'd11;
  localparam logic [3:0] ST_STAT_WAIT    = 4'd12;
  localparam logic [3:0] ST_STAT_STROBE  = 4'd13;
  localparam logic [3:0] ST_FINISH       = 4'd14;

  localparam logic CS_IDLE  = 1'b1;
  localparam logic ACK_IDLE = 1'b1;
  localparam logic RW_IDLE  = 1'b1;
  localparam logic A1_IDLE  = 1'b1;

  localparam logic [7:0] STATUS_TIMEOUT = 8'hFF;

  // The shared counter runs N-1 down to 0, so a phase of N clocks loads N-1.
  function automatic logic [23:0] load_value(input int unsigned cycles);
    if (cycles == 0) return 24'd0;
    return 24'(cycles - 1);
  endfunction

endpackage

// File: rtl/acsi_sync.sv
// Multi-flop synchronizer for the asynchronous active-low target request lines.
module acsi_sync
  import acsi_pkg::*;
#(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] stage_reg;
  logic [STAGES-1:0] stage_next;

  assign stage_next = {stage_reg[STAGES-2:0], async_in};
  assign sync_out   = stage_reg[STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      stage_reg <= {STAGES{RESET_VAL}};
    end else begin
      stage_reg <= stage_next;
    end
  end

endmodule

// File: rtl/acsi_initiator.sv
// ACSI bus master emulating the Atari DMA chip: command block, optional
// DRQ/ACK data phase and status read, fed from valid/ready host streams.
module acsi_initiator
  import acsi_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES    = 2,
  parameter int unsigned STROBE_CYCLES   = 4,
  parameter int unsigned RECOVERY_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  cmd_len,
  input  logic [15:0] xfer_count,
  input  logic        xfer_read,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  status,
  output logic        timeout,
  output logic [7:0]  acsi_data_out,
  input  logic [7:0]  acsi_data_in,
  output logic        acsi_data_oe,
  output logic        acsi_cs_n,
  output logic        acsi_a1,
  output logic        acsi_rw,
  output logic        acsi_ack_n,
  input  logic        acsi_irq_n,
  input  logic        acsi_drq_n
);

  localparam logic [23:0] SETUP_LOAD    = load_value(SETUP_CYCLES);
  localparam logic [23:0] STROBE_LOAD   = load_value(STROBE_CYCLES);
  localparam logic [23:0] RECOVERY_LOAD = load_value(RECOVERY_CYCLES);
  localparam logic [23:0] TIMEOUT_LOAD  = load_value(TIMEOUT_CYCLES);

  acsi_state_t state_reg, state_next;
  logic [23:0] cnt_reg, cnt_next;
  logic [3:0]  idx_reg, idx_next;
  logic [3:0]  len_reg, len_next;
  logic [15:0] remain_reg, remain_next;
  logic        dir_read_reg, dir_read_next;
  logic [7:0]  dout_reg, dout_next;
  logic        oe_reg, oe_next;
  logic        cs_n_reg, cs_n_next;
  logic        ack_n_reg, ack_n_next;
  logic        a1_reg, a1_next;
  logic        rw_reg, rw_next;
  logic [7:0]  rd_data_reg, rd_data_next;
  logic        rd_valid_reg, rd_valid_next;
  logic [7:0]  status_reg, status_next;
  logic        timeout_reg, timeout_next;
  logic        busy_reg, busy_next;

  logic irq_sync_n, drq_sync_n;
  logic irq_active, drq_active;
  logic cnt_zero;
  logic [23:0] cnt_dec;
  logic to_status, abort, go_finish;

  acsi_sync #(.STAGES(2), .RESET_VAL(1'b1)) u_irq_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (acsi_irq_n),
    .sync_out (irq_sync_n)
  );

  acsi_sync #(.STAGES(2), .RESET_VAL(1'b1)) u_drq_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (acsi_drq_n),
    .sync_out (drq_sync_n)
  );

  assign irq_active = ~irq_sync_n;
  assign drq_active = ~drq_sync_n;
  assign cnt_zero   = (cnt_reg == 24'd0);
  assign cnt_dec    = cnt_reg - 24'd1;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    idx_next      = idx_reg;
    len_next      = len_reg;
    remain_next   = remain_reg;
    dir_read_next = dir_read_reg;
    dout_next     = dout_reg;
    oe_next       = oe_reg;
    cs_n_next     = cs_n_reg;
    ack_n_next    = ack_n_reg;
    a1_next       = a1_reg;
    rw_next       = rw_reg;
    rd_data_next  = rd_data_reg;
    rd_valid_next = rd_valid_reg;
    status_next   = status_reg;
    timeout_next  = timeout_reg;
    busy_next     = busy_reg;
    to_status     = 1'b0;
    abort         = 1'b0;
    go_finish     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start && (cmd_len != 4'd0)) begin
          len_next      = cmd_len;
          remain_next   = xfer_count;
          dir_read_next = xfer_read;
          busy_next     = 1'b1;
          timeout_next  = 1'b0;
          idx_next      = 4'd0;
          state_next    = ST_CMD_FETCH;
        end
      end

      ST_CMD_FETCH: begin
        if (cmd_valid) begin
          dout_next  = cmd_data;
          oe_next    = 1'b1;
          rw_next    = 1'b0;
          a1_next    = (idx_reg != 4'd0);
          cnt_next   = SETUP_LOAD;
          state_next = ST_CMD_SETUP;
        end
      end

      ST_CMD_SETUP: begin
        if (cnt_zero) begin
          cs_n_next  = 1'b0;
          cnt_next   = STROBE_LOAD;
          state_next = ST_CMD_STROBE;
        end else begin
          cnt_next = cnt_dec;
        end
      end

      ST_CMD_STROBE: begin
        if (cnt_zero) begin
          cs_n_next  = CS_IDLE;
          cnt_next   = RECOVERY_LOAD;
          state_next = ST_CMD_RECOVER;
        end else begin
          cnt_next = cnt_dec;
        end
      end

      ST_CMD_RECOVER: begin
        if (cnt_zero) begin
          oe_next  = 1'b0;
          a1_next  = A1_IDLE;
          cnt_next = TIMEOUT_LOAD;
          if ((idx_reg + 4'd1) < len_reg) begin
            state_next = ST_WAIT_IRQ;
          end else if (remain_reg != 16'd0) begin
            rw_next    = dir_read_reg;
            state_next = ST_DATA_WAIT;
          end else begin
            to_status = 1'b1;
          end
        end else begin
          cnt_next = cnt_dec;
        end
      end

      ST_WAIT_IRQ: begin
        if (irq_active) begin
          idx_next   = idx_reg + 4'd1;
          state_next = ST_CMD_FETCH;
        end else if (cnt_zero) begin
          abort = 1'b1;
        end else begin
          cnt_next = cnt_dec;
        end
      end

      ST_DATA_WAIT: begin
        if (drq_active) begin
          cnt_next   = SETUP_LOAD;
          state_next = dir_read_reg ? ST_DATA_SETUP : ST_DATA_FETCH;
        end else if (cnt_zero) begin
          abort = 1'b1;
        end else begin
          cnt_next = cnt_dec;
        end
      end

      ST_DATA_FETCH: begin
        if (wr_valid) begin
          dout_next  = wr_data;
          oe_next    = 1'b1;
          cnt_next   = SETUP_LOAD;
          state_next = ST_DATA_SETUP;
        end
      end

      ST_DATA_SETUP: begin
        if (cnt_zero) begin
          ack_n_next = 1'b0;
          cnt_next   = STROBE_LOAD;
          state_next = ST_DATA_STROBE;
        end else begin
          cnt_next = cnt_dec;
        end
      end

      ST_DATA_STROBE: begin
        if (cnt_zero) begin
          ack_n_next = ACK_IDLE;
          if (dir_read_reg) rd_data_next = acsi_data_in;
          cnt_next   = RECOVERY_LOAD;
          state_next = ST_DATA_RECOVER;
        end else begin
          cnt_next = cnt_dec;
        end
      end

      ST_DATA_RECOVER: begin
        if (cnt_zero) begin
          remain_next = remain_reg - 16'd1;
          oe_next     = 1'b0;
          if (dir_read_reg) begin
            rd_valid_next = 1'b1;
            state_next    = ST_RD_HOLD;
          end else if (remain_reg == 16'd1) begin
            to_status = 1'b1;
          end else begin
            cnt_next   = TIMEOUT_LOAD;
            state_next = ST_DATA_WAIT;
          end
        end else begin
          cnt_next = cnt_dec;
        end
      end

      // DRQ is deliberately ignored here until the host drains the byte.
      ST_RD_HOLD: begin
        if (rd_ready) begin
          rd_valid_next = 1'b0;
          if (remain_reg == 16'd0) begin
            to_status = 1'b1;
          end else begin
            cnt_next   = TIMEOUT_LOAD;
            state_next = ST_DATA_WAIT;
          end
        end
      end

      ST_STAT_WAIT: begin
        if (irq_active) begin
          cs_n_next  = 1'b0;
          cnt_next   = STROBE_LOAD;
          state_next = ST_STAT_STROBE;
        end else if (cnt_zero) begin
          abort = 1'b1;
        end else begin
          cnt_next = cnt_dec;
        end
      end

      ST_STAT_STROBE: begin
        if (cnt_zero) begin
          status_next = acsi_data_in;
          go_finish   = 1'b1;
        end else begin
          cnt_next = cnt_dec;
        end
      end

      ST_FINISH: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Direction lines settle while waiting for IRQ, well ahead of the status CS.
    if (to_status) begin
      rw_next    = 1'b1;
      a1_next    = 1'b1;
      oe_next    = 1'b0;
      cnt_next   = TIMEOUT_LOAD;
      state_next = ST_STAT_WAIT;
    end

    if (abort) begin
      timeout_next = 1'b1;
      status_next  = STATUS_TIMEOUT;
      go_finish    = 1'b1;
    end

    if (go_finish) begin
      cs_n_next     = CS_IDLE;
      ack_n_next    = ACK_IDLE;
      rw_next       = RW_IDLE;
      a1_next       = A1_IDLE;
      oe_next       = 1'b0;
      dout_next     = 8'h00;
      rd_valid_next = 1'b0;
      busy_next     = 1'b0;
      state_next    = ST_FINISH;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 24'd0;
      idx_reg      <= 4'd0;
      len_reg      <= 4'd0;
      remain_reg   <= 16'd0;
      dir_read_reg <= 1'b0;
      dout_reg     <= 8'h00;
      oe_reg       <= 1'b0;
      cs_n_reg     <= CS_IDLE;
      ack_n_reg    <= ACK_IDLE;
      a1_reg       <= A1_IDLE;
      rw_reg       <= RW_IDLE;
      rd_data_reg  <= 8'h00;
      rd_valid_reg <= 1'b0;
      status_reg   <= 8'h00;
      timeout_reg  <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      len_reg      <= len_next;
      remain_reg   <= remain_next;
      dir_read_reg <= dir_read_next;
      dout_reg     <= dout_next;
      oe_reg       <= oe_next;
      cs_n_reg     <= cs_n_next;
      ack_n_reg    <= ack_n_next;
      a1_reg       <= a1_next;
      rw_reg       <= rw_next;
      rd_data_reg  <= rd_data_next;
      rd_valid_reg <= rd_valid_next;
      status_reg   <= status_next;
      timeout_reg  <= timeout_next;
      busy_reg     <= busy_next;
    end
  end

  assign cmd_ready     = (state_reg == ST_CMD_FETCH);
  assign wr_ready      = (state_reg == ST_DATA_FETCH);
  assign done          = (state_reg == ST_FINISH);
  assign busy          = busy_reg;
  assign rd_data       = rd_data_reg;
  assign rd_valid      = rd_valid_reg;
  assign status        = status_reg;
  assign timeout       = timeout_reg;
  assign acsi_data_out = dout_reg;
  assign acsi_data_oe  = oe_reg;
  assign acsi_cs_n     = cs_n_reg;
  assign acsi_a1       = a1_reg;
  assign acsi_rw       = rw_reg;
  assign acsi_ack_n    = ack_n_reg;

endmodule

// File: tb/tb_acsi_initiator.sv
// Bench for acsi_initiator: behavioural ACSI target plus host stream drivers,
// with queue-based scoreboards for command, write and read bytes.
module tb_acsi_initiator;

  localparam int SETUP  = 2;
  localparam int STROBE = 4;
  localparam int RECOV  = 4;
  localparam int TMO    = 300;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  cmd_len = 4'd0;
  logic [15:0] xfer_count = 16'd0;
  logic        xfer_read = 1'b0;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic        busy, done, timeout;
  logic [7:0]  status;
  logic [7:0]  acsi_data_out;
  logic [7:0]  acsi_data_in = 8'h00;
  logic        acsi_data_oe, acsi_cs_n, acsi_a1, acsi_rw, acsi_ack_n;
  logic        acsi_irq_n = 1'b1;
  logic        acsi_drq_n = 1'b1;

  always #5 clock = ~clock;

  acsi_initiator #(
    .SETUP_CYCLES(SETUP), .STROBE_CYCLES(STROBE),
    .RECOVERY_CYCLES(RECOV), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .cmd_len(cmd_len),
    .xfer_count(xfer_count), .xfer_read(xfer_read),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .status(status), .timeout(timeout),
    .acsi_data_out(acsi_data_out), .acsi_data_in(acsi_data_in),
    .acsi_data_oe(acsi_data_oe), .acsi_cs_n(acsi_cs_n), .acsi_a1(acsi_a1),
    .acsi_rw(acsi_rw), .acsi_ack_n(acsi_ack_n),
    .acsi_irq_n(acsi_irq_n), .acsi_drq_n(acsi_drq_n)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboards
  logic [7:0] cmd_src[$];
  logic [8:0] cmd_exp[$];
  logic [7:0] wr_src[$];
  logic [7:0] wr_exp[$];
  logic [7:0] rd_exp[$];

  // target model state
  bit         tgt_active = 0;
  bit         tgt_read = 0;
  bit         tgt_hang = 0;
  int         tgt_cmd_len = 0;
  int         tgt_xfer = 0;
  logic [7:0] tgt_status = 8'h00;
  int cmd_seen, data_seen, cs_pulses, ack_pulses, done_cnt, rd_got, cyc;
  int cs_low, ack_low, stable_cnt;
  logic prev_cs, prev_ack, cs_rw;
  logic [10:0] prev_bus, cur_bus;

  task automatic tgt_next_beat();
    if (tgt_read) begin
      acsi_data_in = 8'(data_seen & 255);
      rd_exp.push_back(acsi_data_in);
    end
    acsi_drq_n = 1'b0;
  endtask

  initial begin
    prev_cs = 1'b1; prev_ack = 1'b1; prev_bus = '0; stable_cnt = 0;
    cs_low = 0; ack_low = 0; cyc = 0; done_cnt = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (done) done_cnt++;
      cur_bus = {acsi_data_oe, acsi_rw, acsi_a1, acsi_data_out};
      if (cur_bus != prev_bus) stable_cnt = 0;
      else stable_cnt++;
      prev_bus = cur_bus;
      if (!tgt_active) begin
        acsi_irq_n = 1'b1; acsi_drq_n = 1'b1; cs_low = 0; ack_low = 0;
      end else begin
        if (!acsi_cs_n && prev_cs) begin
          cs_low = 1; cs_pulses++; acsi_irq_n = 1'b1; cs_rw = acsi_rw;
          if (!acsi_rw) begin
            check_eq("cmd_setup", 32'(stable_cnt >= SETUP), 1);
            check_eq("cmd_oe", acsi_data_oe, 1);
            if (cmd_exp.size() == 0) check_eq("cmd_q", cmd_exp.size(), 1);
            else check_eq("cmd_byte", {acsi_a1, acsi_data_out}, cmd_exp.pop_front());
          end else begin
            check_eq("stat_oe", acsi_data_oe, 0);
          end
        end else if (!acsi_cs_n) begin
          cs_low++;
        end else if (!prev_cs) begin
          check_eq("cs_width", cs_low, STROBE);
          cs_low = 0;
          if (!cs_rw) begin
            cmd_seen++;
            if (cmd_seen < tgt_cmd_len) begin
              if (!tgt_hang) acsi_irq_n = 1'b0;
            end else if (tgt_xfer > 0) begin
              tgt_next_beat();
            end else begin
              acsi_data_in = tgt_status; acsi_irq_n = 1'b0;
            end
          end
        end
        if (!acsi_ack_n && prev_ack) begin
          ack_low = 1; ack_pulses++; acsi_drq_n = 1'b1;
          check_eq("ack_rdv", rd_valid, 0);
          check_eq("ack_setup", 32'(stable_cnt >= SETUP), 1);
          check_eq("ack_rw", acsi_rw, tgt_read);
          if (!tgt_read) begin
            check_eq("wr_oe", acsi_data_oe, 1);
            if (wr_exp.size() == 0) check_eq("wr_q", wr_exp.size(), 1);
            else check_eq("wr_byte", acsi_data_out, wr_exp.pop_front());
          end
        end else if (!acsi_ack_n) begin
          ack_low++;
        end else if (!prev_ack) begin
          check_eq("ack_width", ack_low, STROBE);
          ack_low = 0; data_seen++;
          if (data_seen < tgt_xfer) tgt_next_beat();
          else begin
            acsi_data_in = tgt_status; acsi_irq_n = 1'b0;
          end
        end
      end
      prev_cs = acsi_cs_n; prev_ack = acsi_ack_n;
    end
  end

  // host-side stream drivers; a handshake decided at a negedge completes at the next posedge
  bit cmd_hs = 0, wr_hs = 0;
  initial begin
    forever begin
      @(negedge clock);
      if (cmd_hs && cmd_src.size() > 0) void'(cmd_src.pop_front());
      if (cmd_hs) cmd_valid = 1'b0;
      if (!cmd_valid && cmd_src.size() > 0 && $urandom_range(0, 3) != 0) begin
        cmd_valid = 1'b1; cmd_data = cmd_src[0];
      end
      if (cmd_src.size() == 0) cmd_valid = 1'b0;
      cmd_hs = cmd_valid && cmd_ready;

      if (wr_hs && wr_src.size() > 0) void'(wr_src.pop_front());
      if (wr_hs) wr_valid = 1'b0;
      if (!wr_valid && wr_src.size() > 0 && $urandom_range(0, 2) == 0) begin
        wr_valid = 1'b1; wr_data = wr_src[0];
      end
      if (wr_src.size() == 0) wr_valid = 1'b0;
      wr_hs = wr_valid && wr_ready;

      rd_ready = 1'($urandom_range(0, 1));
      if (rd_valid && rd_ready) begin
        rd_got++;
        if (rd_exp.size() == 0) check_eq("rd_q", rd_exp.size(), 1);
        else check_eq("rd_data", rd_data, rd_exp.pop_front());
      end
    end
  end

  task automatic begin_txn(input int clen, input int xcount, input bit rd, input bit hang,
                           input logic [7:0] st);
    logic [7:0] b;
    tgt_cmd_len = clen; tgt_xfer = xcount; tgt_read = rd; tgt_hang = hang; tgt_status = st;
    cmd_seen = 0; data_seen = 0; cs_pulses = 0; ack_pulses = 0; done_cnt = 0; rd_got = 0;
    for (int i = 0; i < clen; i++) begin
      b = 8'($urandom);
      cmd_src.push_back(b);
      cmd_exp.push_back({1'(i != 0), b});
    end
    if (!rd) begin
      for (int i = 0; i < xcount; i++) begin
        b = 8'($urandom);
        wr_src.push_back(b);
        wr_exp.push_back(b);
      end
    end
    tgt_active = 1;
    @(negedge clock);
    start = 1'b1; cmd_len = 4'(clen); xfer_count = 16'(xcount); xfer_read = rd;
    @(negedge clock);
    start = 1'b0;
    check_eq("busy_on_start", busy, 1);
    check_eq("timeout_cleared", timeout, 0);
  endtask

  task automatic flush_queues();
    cmd_src.delete(); cmd_exp.delete(); wr_src.delete(); wr_exp.delete(); rd_exp.delete();
  endtask

  task automatic run_txn(input string name, input int clen, input int xcount, input bit rd,
                         input bit hang, input logic [7:0] st, input bit extra_start);
    bit got_done;
    int t_done;
    begin_txn(clen, xcount, rd, hang, st);
    got_done = 0; t_done = 0;
    for (int c = 0; c < 30000 && !got_done; c++) begin
      @(negedge clock);
      start = extra_start && (c == 20);
      if (done) begin
        got_done = 1; t_done = c;
        check_eq({name, ":busy_at_done"}, busy, 0);
      end
    end
    start = 1'b0;
    check_eq({name, ":done_seen"}, got_done, 1);
    repeat (6) @(negedge clock);
    check_eq({name, ":done_pulses"}, done_cnt, 1);
    check_eq({name, ":status"}, status, hang ? 8'hFF : st);
    check_eq({name, ":timeout"}, timeout, hang);
    check_eq({name, ":cs_pulses"}, cs_pulses, hang ? 1 : clen + 1);
    check_eq({name, ":ack_pulses"}, ack_pulses, hang ? 0 : xcount);
    check_eq({name, ":bus_idle"}, {acsi_cs_n, acsi_ack_n, acsi_rw, acsi_a1, acsi_data_oe, acsi_data_out},
             {5'b11110, 8'h00});
    if (hang) begin
      check_eq({name, ":tmo_min"}, 32'(t_done >= TMO), 1);
      check_eq({name, ":tmo_max"}, 32'(t_done <= TMO + 40), 1);
    end else begin
      check_eq({name, ":rd_count"}, rd_got, rd ? xcount : 0);
      check_eq({name, ":cmd_left"}, cmd_exp.size(), 0);
      check_eq({name, ":wr_left"}, wr_exp.size(), 0);
      check_eq({name, ":rd_left"}, rd_exp.size(), 0);
    end
    $display("txn %s: cmd_len=%0d xfer=%0d read=%0d status=0x%02h timeout=%0d cs=%0d ack=%0d",
             name, clen, xcount, rd, status, timeout, cs_pulses, ack_pulses);
    tgt_active = 0;
    flush_queues();
    repeat (3) @(negedge clock);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_cs_n", acsi_cs_n, 1);
    check_eq("rst_ack_n", acsi_ack_n, 1);
    check_eq("rst_rw", acsi_rw, 1);
    check_eq("rst_a1", acsi_a1, 1);
    check_eq("rst_oe", acsi_data_oe, 0);
    check_eq("rst_dout", acsi_data_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_wr_ready", wr_ready, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_status", status, 0);
    $display("txn reset: idle levels checked");

    // 6-byte command, no data phase; a start pulse while busy must be ignored
    run_txn("cmd6", 6, 0, 0, 0, 8'h00, 1);

    // start with cmd_len=0 must be ignored
    cs_pulses = 0; done_cnt = 0; tgt_active = 1;
    @(negedge clock);
    start = 1'b1; cmd_len = 4'd0; xfer_count = 16'd0;
    @(negedge clock);
    start = 1'b0;
    repeat (30) @(negedge clock);
    check_eq("len0:busy", busy, 0);
    check_eq("len0:cs_pulses", cs_pulses, 0);
    check_eq("len0:done", done_cnt, 0);
    $display("txn len0: busy=%0d cs=%0d done=%0d", busy, cs_pulses, done_cnt);
    tgt_active = 0;

    run_txn("rd512", 6, 512, 1, 0, 8'h5A, 0);
    run_txn("wr16", 6, 16, 0, 0, 8'hC3, 0);
    run_txn("tmo", 6, 0, 0, 1, 8'h00, 0);

    // reset during a write data strobe
    begin_txn(2, 8, 0, 0, 8'h11);
    found = 0;
    for (int c = 0; c < 5000 && !found; c++) begin
      @(negedge clock);
      if (!acsi_ack_n) found = 1;
    end
    check_eq("rst_mid:ack_seen", found, 1);
    reset = 1'b1; tgt_active = 0;
    @(negedge clock);
    check_eq("rst_mid:ack_n", acsi_ack_n, 1);
    check_eq("rst_mid:oe", acsi_data_oe, 0);
    check_eq("rst_mid:busy", busy, 0);
    check_eq("rst_mid:cs_n", acsi_cs_n, 1);
    check_eq("rst_mid:done", done, 0);
    reset = 1'b0;
    flush_queues();
    repeat (4) @(negedge clock);
    $display("txn rst_mid: ack_n=%0d oe=%0d busy=%0d", acsi_ack_n, acsi_data_oe, busy);

    run_txn("post_rst", 1, 4, 1, 0, 8'h42, 0);
    run_txn("wr3", 3, 3, 0, 0, 8'h07, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acsi_initiator.md
Name: acsi_initiator

Overview:
Host-side ACSI bus master. It is the initiator counterpart to the team's ACSI target bridge, and it emulates the Atari DMA chip.
- Sends a command block: first byte with A1 low, remaining bytes with A1 high, each later byte gated by the target's IRQ.
- Runs an optional DRQ/ACK data phase in either direction, then reads the status byte.
- Used as a bench/host adapter that drives the disk FPGA from an on-board controller through simple valid/ready streams.

Parameters:
SETUP_CYCLES, 2, cycles that data/A1/RW are held stable before a CS or ACK strobe falls.
STROBE_CYCLES, 4, low width of cs_n/ack_n strobes, in clocks.
RECOVERY_CYCLES, 4, clocks after a strobe releases before irq_n/drq_n may be sampled again.
TIMEOUT_CYCLES, 1000000, maximum clocks spent waiting for IRQ/DRQ before aborting (24-bit counter).

Ports:
clock  in  1  system clock; single clock domain.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to begin a transaction; ignored while busy or when cmd_len==0.
cmd_len  in  4  number of command bytes (1..15); sampled on start.
xfer_count  in  16  data-phase byte count; 0 = no data phase; sampled on start.
xfer_read  in  1  1 = target-to-host data phase; sampled on start.
cmd_data  in  8  command byte stream.
cmd_valid  in  1  cmd_data valid.
cmd_ready  out  1  command byte accepted when valid&ready.
wr_data  in  8  write-phase data stream.
wr_valid  in  1  wr_data valid.
wr_ready  out  1  wr byte accepted when valid&ready.
rd_data  out  8  read-phase data.
rd_valid  out  1  rd_data valid; held until rd_ready.
rd_ready  in  1  consumer accepts rd_data.
busy  out  1  transaction in progress.
done  out  1  one-cycle pulse at transaction end.
status  out  8  status byte from target; 0xFF on timeout; held until next start.
timeout  out  1  set with done if a wait expired; cleared on start.
acsi_data_out  out  8  bus data driven by initiator.
acsi_data_in  in  8  bus data from target.
acsi_data_oe  out  1  1 = initiator drives bus.
acsi_cs_n  out  1  chip select strobe, active low.
acsi_a1  out  1  0 = first command byte, 1 otherwise.
acsi_rw  out  1  1 = read from target, 0 = write.
acsi_ack_n  out  1  data-phase strobe, active low.
acsi_irq_n  in  1  target IRQ, active low, asynchronous.
acsi_drq_n  in  1  target DRQ, active low, asynchronous.

Behaviour:
- Reset/idle values:
  - Bus lines: cs_n=1, ack_n=1, rw=1, a1=1, data_oe=0, data_out=0.
  - Host outputs: busy=0, done=0, cmd_ready=0, wr_ready=0, rd_valid=0, timeout=0, status=0x00.
  - Reset mid-transaction returns to IDLE on the next clock and drops all strobes immediately; no done pulse.
- Input synchronisation: irq_n and drq_n each pass through a 2-flop synchronizer. IRQ/DRQ mean synchronized value == 0.
- States: IDLE, CMD_FETCH, CMD_SETUP, CMD_STROBE, CMD_RECOVER, WAIT_IRQ, DATA_WAIT, DATA_FETCH, DATA_SETUP, DATA_STROBE, DATA_RECOVER, RD_HOLD, STAT_WAIT, STAT_STROBE, FINISH.
- IDLE: on a valid start, latch the parameters, set busy=1, clear timeout, byte index=0, go to CMD_FETCH.
- CMD_FETCH:
  - cmd_ready=1 until handshake completes.
  - On handshake: latch byte, data_oe=1, rw=0, a1=(index!=0); go to CMD_SETUP.
  - Host stalls do not count toward timeout.
- CMD_SETUP: SETUP_CYCLES clocks, then CMD_STROBE.
- CMD_STROBE: cs_n=0 for STROBE_CYCLES, then cs_n=1 and go to CMD_RECOVER. Data is held through this state.
- CMD_RECOVER: RECOVERY_CYCLES with data still driven, then data_oe=0. Then:
  - more command bytes remain: WAIT_IRQ;
  - else xfer_count>0: DATA_WAIT;
  - else STAT_WAIT.
- WAIT_IRQ: wait for IRQ, then CMD_FETCH (index+1).
- Data phase, rw=xfer_read:
  - DATA_WAIT waits for DRQ.
  - Write: go to DATA_FETCH (wr_ready handshake), drive data, then DATA_SETUP.
  - Read: go directly to DATA_SETUP.
  - DATA_STROBE drives ack_n=0 for STROBE_CYCLES. Reads sample acsi_data_in on the last low cycle.
  - DATA_RECOVER lasts RECOVERY_CYCLES and decrements the remaining count.
  - Read: go to RD_HOLD (rd_valid=1 until rd_ready). DRQ is not serviced while rd_valid is pending.
  - Count==0: STAT_WAIT; else DATA_WAIT.
- STAT_WAIT: wait for IRQ.
- STAT_STROBE: rw=1, a1=1, cs_n=0 for STROBE_CYCLES; status captured on the last low cycle. Then FINISH.
- FINISH: done=1 for one clock, busy=0, release all bus lines, go to IDLE.
- Timeout:
  - Counter cleared on entry to each IRQ/DRQ wait state.
  - On reaching TIMEOUT_CYCLES: timeout=1, status=0xFF, release bus, go to FINISH.
- Simultaneous start and reset: reset wins.
- xfer_count=0xFFFF is a valid full 65535-byte transfer.

Decomposition:
- Package acsi_pkg: state enum, bus idle-level constants (CS/ACK/RW/A1), STATUS_TIMEOUT=8'hFF.
- Sub-module acsi_sync: 2-flop synchronizer, instantiated once each for irq_n and drq_n.
- Wait/strobe timing uses a single shared down-counter in the main module.

Test Plan:
- 6-byte command, xfer_count=0; target model pulls IRQ after each byte and returns status 0x00 → 6 cs_n pulses each STROBE_CYCLES long, A1 = 0,1,1,1,1,1, rw=0; then one read strobe; status=0x00, one done pulse, timeout=0.
- Read of 512 bytes, pattern i&0xFF, rd_ready toggling 50% → 512 ack_n pulses; rd_data matches the pattern in order; no ack while rd_valid is pending.
- Write of 16 bytes with wr_valid gaps → 16 ack_n pulses; data stable SETUP_CYCLES before each ack_n falls; bytes captured by the target equal wr_data.
- IRQ never asserted after the first command byte → timeout=1, status=0xFF, done after ~TIMEOUT_CYCLES; bus lines at idle levels.
- Reset asserted during DATA_STROBE → next clock ack_n=1, data_oe=0, busy=0; a new transaction then completes normally.
- start pulsed while busy, and start with cmd_len=0 → both ignored; no extra cs_n strobe, no done pulse.
